// File: rtl/mul_char_pkg.sv
// Shared types and width helpers for the approximate-multiplier
// characterisation engine.
package mul_char_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Nominal operand width of the multipliers being characterised
    localparam int W_DEF  = 4;

    // Derived widths at the nominal operand width
    localparam int PW     = 2 * W_DEF;
    localparam int CNT_W  = 2 * W_DEF + 1;
    localparam int SUM_W  = 4 * W_DEF;
    localparam int BIAS_W = 4 * W_DEF + 1;

    // Same derivations for an arbitrary operand width
    function automatic int pw_of(input int w);
        return 2 * w;
    endfunction

    function automatic int cnt_w_of(input int w);
        return 2 * w + 1;
    endfunction

    function automatic int sum_w_of(input int w);
        return 4 * w;
    endfunction

    function automatic int bias_w_of(input int w);
        return 4 * w + 1;
    endfunction

endpackage

// File: rtl/mul_err_acc.sv
// Compare stage and error accumulators: exact product, signed error,
// absolute error, and first-occurrence worst-case tracking.
module mul_err_acc
    import mul_char_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clr,
    input  logic                           vld,
    input  logic [W-1:0]                   a,
    input  logic [W-1:0]                   b,
    input  logic [pw_of(W)-1:0]            p,
    output logic [cnt_w_of(W)-1:0]         err_cnt,
    output logic [sum_w_of(W)-1:0]         sum_abs,
    output logic signed [bias_w_of(W)-1:0] bias,
    output logic [pw_of(W)-1:0]            max_err,
    output logic [W-1:0]                   wce_a,
    output logic [W-1:0]                   wce_b
);

    localparam int P_W = pw_of(W);
    localparam int C_W = cnt_w_of(W);
    localparam int S_W = sum_w_of(W);
    localparam int B_W = bias_w_of(W);

    logic [P_W-1:0]        exact;
    logic signed [P_W:0]   diff;
    logic signed [P_W:0]   diff_neg;
    logic [P_W-1:0]        absd;

    // Exact product and error of the returned product; |diff| never exceeds 2^P_W-1
    always_comb begin
        exact    = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        diff     = $signed({1'b0, p}) - $signed({1'b0, exact});
        diff_neg = -diff;
        absd     = diff[P_W] ? diff_neg[P_W-1:0] : diff[P_W-1:0];
    end

    // Accumulate metrics on each aligned compare; strict '>' keeps the first worst case
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            err_cnt <= '0;
            sum_abs <= '0;
            bias    <= '0;
            max_err <= '0;
            wce_a   <= '0;
            wce_b   <= '0;
        end else if (vld) begin
            err_cnt <= err_cnt + C_W'(diff != '0);
            sum_abs <= sum_abs + {{(S_W-P_W){1'b0}}, absd};
            bias    <= bias + $signed({{(B_W-P_W-1){diff[P_W]}}, diff});
            if (absd > max_err) begin
                max_err <= absd;
                wce_a   <= a;
                wce_b   <= b;
            end
        end
    end

endmodule

// File: rtl/mul_err_sweep.sv
// Sweep engine: walks every operand pair through an attached multiplier,
// re-aligns the returned product with its operands and feeds the
// compare/accumulate stage.
module mul_err_sweep
    import mul_char_pkg::*;
#(
    parameter int W       = W_DEF,
    parameter int DUT_LAT = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    output logic [W-1:0]                   a_o,
    output logic [W-1:0]                   b_o,
    input  logic [pw_of(W)-1:0]            p_i,
    output logic                           busy,
    output logic                           done,
    output logic [cnt_w_of(W)-1:0]         err_cnt,
    output logic [sum_w_of(W)-1:0]         sum_abs,
    output logic signed [bias_w_of(W)-1:0] bias,
    output logic [pw_of(W)-1:0]            mae,
    output logic [pw_of(W)-1:0]            max_err,
    output logic [W-1:0]                   wce_a,
    output logic [W-1:0]                   wce_b
);

    localparam int P_W  = pw_of(W);
    localparam int S_W  = sum_w_of(W);
    localparam int DC_W = (DUT_LAT > 1) ? $clog2(DUT_LAT) : 1;

    localparam logic [P_W-1:0]  IDX_LAST   = '1;
    localparam logic [DC_W-1:0] DRAIN_LAST = DC_W'(DUT_LAT - 1);

    state_t          state;
    logic [P_W-1:0]  idx;
    logic [DC_W-1:0] drain_cnt;
    logic            vld_p0;
    logic            clr_acc;

    logic [W-1:0]    cmp_a;
    logic [W-1:0]    cmp_b;
    logic            cmp_vld;

    // Accumulators restart on the same edge a sweep is accepted
    assign clr_acc = start && (state == ST_IDLE || state == ST_DONE);

    // Sweep FSM with registered operands, issue-valid, busy and done
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            idx       <= '0;
            drain_cnt <= '0;
            vld_p0    <= 1'b0;
            a_o       <= '0;
            b_o       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state  <= ST_SWEEP;
                        idx    <= '0;
                        a_o    <= '0;
                        b_o    <= '0;
                        vld_p0 <= 1'b1;
                        busy   <= 1'b1;
                        done   <= 1'b0;
                    end
                end
                ST_SWEEP: begin
                    if (idx == IDX_LAST) begin
                        vld_p0 <= 1'b0;
                        a_o    <= '0;
                        b_o    <= '0;
                        if (DUT_LAT > 0) begin
                            state     <= ST_DRAIN;
                            drain_cnt <= '0;
                        end else begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        idx        <= idx + 1'b1;
                        {b_o, a_o} <= idx + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    generate
        if (DUT_LAT == 0) begin : g_nodly
            assign cmp_a   = a_o;
            assign cmp_b   = b_o;
            assign cmp_vld = vld_p0;
        end else begin : g_dly
            logic [W-1:0] a_p   [DUT_LAT];
            logic [W-1:0] b_p   [DUT_LAT];
            logic         vld_p [DUT_LAT];

            // Delay issued operands by the multiplier latency so they meet their product
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DUT_LAT; i++) begin
                        a_p[i]   <= '0;
                        b_p[i]   <= '0;
                        vld_p[i] <= 1'b0;
                    end
                end else begin
                    a_p[0]   <= a_o;
                    b_p[0]   <= b_o;
                    vld_p[0] <= vld_p0;
                    for (int i = 1; i < DUT_LAT; i++) begin
                        a_p[i]   <= a_p[i-1];
                        b_p[i]   <= b_p[i-1];
                        vld_p[i] <= vld_p[i-1];
                    end
                end
            end

            assign cmp_a   = a_p[DUT_LAT-1];
            assign cmp_b   = b_p[DUT_LAT-1];
            assign cmp_vld = vld_p[DUT_LAT-1];
        end
    endgenerate

    mul_err_acc #(
        .W (W)
    ) u_acc (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr_acc),
        .vld     (cmp_vld),
        .a       (cmp_a),
        .b       (cmp_b),
        .p       (p_i),
        .err_cnt (err_cnt),
        .sum_abs (sum_abs),
        .bias    (bias),
        .max_err (max_err),
        .wce_a   (wce_a),
        .wce_b   (wce_b)
    );

    // Mean over 2^(2W) pairs is a plain right shift
    assign mae = sum_abs[S_W-1:P_W];

endmodule

// File: tb/tb_mul_err_sweep.sv
// Scoreboard bench for mul_err_sweep: one combinational-latency instance
// driven by selectable multiplier models, one 2-cycle-latency instance.
module tb_mul_err_sweep;

    localparam int W  = 4;
    localparam int NP = 256;

    typedef struct {
        int err;
        int sum;
        int bias;
        int mae;
        int maxe;
        int wa;
        int wb;
        bit nz_only;
        int blen;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start0 = 1'b0;
    logic start2 = 1'b0;

    logic [3:0] a0, b0, a2, b2;
    logic [7:0] p0, p2;
    logic busy0, done0, busy2, done2;
    logic [8:0] err0, err2;
    logic [15:0] sum0, sum2;
    logic signed [16:0] bias0, bias2;
    logic [7:0] mae0, mae2, max0, max2;
    logic [3:0] wa0, wb0, wa2, wb2;

    int mode0 = 0;
    bit mis2 = 1'b0;
    logic [7:0] lut [NP];
    logic [7:0] r1 = '0;
    logic [7:0] r2 = '0;

    int n_tests = 0;
    int n_fail = 0;
    exp_t q0[$];
    exp_t q2[$];

    always #5 clk = ~clk;

    mul_err_sweep #(.W(W), .DUT_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .a_o(a0), .b_o(b0), .p_i(p0),
        .busy(busy0), .done(done0), .err_cnt(err0), .sum_abs(sum0), .bias(bias0),
        .mae(mae0), .max_err(max0), .wce_a(wa0), .wce_b(wb0)
    );

    mul_err_sweep #(.W(W), .DUT_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a_o(a2), .b_o(b2), .p_i(p2),
        .busy(busy2), .done(done2), .err_cnt(err2), .sum_abs(sum2), .bias(bias2),
        .mae(mae2), .max_err(max2), .wce_a(wa2), .wce_b(wb2)
    );

    // Multiplier models: 0 exact, 1 stuck-at-zero, 2 constant one, 3 offset +1, 4 table
    function automatic int p_model(input int mode, input int a, input int b);
        case (mode)
            0: return a * b;
            1: return 0;
            2: return 1;
            3: return a * b + 1;
            default: return int'(lut[b * 16 + a]);
        endcase
    endfunction

    always_comb p0 = 8'(p_model(mode0, int'(a0), int'(b0)));

    // Two-stage registered exact multiplier; the misaligned variant taps one stage early
    always @(posedge clk) begin
        r1 <= 8'(a2) * 8'(b2);
        r2 <= r1;
    end
    assign p2 = mis2 ? r1 : r2;

    // Reference metrics over every pair in sweep order (b outer, a inner)
    function automatic exp_t ref_model(input int mode);
        exp_t e;
        int d, ad;
        e = '{default: 0};
        e.maxe = 0;
        for (int b = 0; b < 16; b++) begin
            for (int a = 0; a < 16; a++) begin
                d  = p_model(mode, a, b) - a * b;
                ad = (d < 0) ? -d : d;
                if (d != 0) e.err++;
                e.sum  += ad;
                e.bias += d;
                if (ad > e.maxe) begin
                    e.maxe = ad;
                    e.wa   = a;
                    e.wb   = b;
                end
            end
        end
        e.mae  = e.sum / NP;
        e.blen = NP;
        return e;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_result(input string tag, input exp_t e, input int err, input int sum,
                                input int bias, input int mae, input int maxe, input int wa,
                                input int wb, input int blen, input bit seq_ok);
        check({tag, "_busy_len"}, blen, e.blen);
        check({tag, "_op_seq"}, int'(seq_ok), 1);
        if (e.nz_only) begin
            check({tag, "_err_nonzero"}, int'(err > 0), 1);
        end else begin
            check({tag, "_err_cnt"}, err, e.err);
            check({tag, "_sum_abs"}, sum, e.sum);
            check({tag, "_bias"}, bias, e.bias);
            check({tag, "_mae"}, mae, e.mae);
            check({tag, "_max_err"}, maxe, e.maxe);
            check({tag, "_wce_a"}, wa, e.wa);
            check({tag, "_wce_b"}, wb, e.wb);
        end
    endtask

    // Monitor for the zero-latency instance: tracks busy length and operand order, checks on done
    initial begin : mon0
        bit pb = 1'b0, pd = 1'b0, seq_ok = 1'b1;
        int bcnt = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (busy0 && !pb) begin
                bcnt = 0;
                seq_ok = 1'b1;
            end
            if (busy0) begin
                if (bcnt < NP && int'({b0, a0}) != bcnt) seq_ok = 1'b0;
                bcnt++;
            end
            if (done0 && !pd) begin
                if (q0.size() == 0) begin
                    check("sb0_unexpected_done", 1, 0);
                end else begin
                    e = q0.pop_front();
                    check_result("lat0", e, int'(err0), int'(sum0), int'(bias0), int'(mae0),
                                 int'(max0), int'(wa0), int'(wb0), bcnt, seq_ok);
                end
            end
            pb = busy0;
            pd = done0;
        end
    end

    // Monitor for the two-cycle-latency instance
    initial begin : mon2
        bit pb = 1'b0, pd = 1'b0, seq_ok = 1'b1;
        int bcnt = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (busy2 && !pb) begin
                bcnt = 0;
                seq_ok = 1'b1;
            end
            if (busy2) begin
                if (bcnt < NP && int'({b2, a2}) != bcnt) seq_ok = 1'b0;
                bcnt++;
            end
            if (done2 && !pd) begin
                if (q2.size() == 0) begin
                    check("sb2_unexpected_done", 1, 0);
                end else begin
                    e = q2.pop_front();
                    check_result("lat2", e, int'(err2), int'(sum2), int'(bias2), int'(mae2),
                                 int'(max2), int'(wa2), int'(wb2), bcnt, seq_ok);
                end
            end
            pb = busy2;
            pd = done2;
        end
    end

    task automatic wait_done0(input int limit);
        bit seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (done0) seen = 1'b1;
        end
        check("lat0_done_timeout", int'(seen), 1);
        @(negedge clk);
    endtask

    task automatic wait_done2(input int limit);
        bit seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (done2) seen = 1'b1;
        end
        check("lat2_done_timeout", int'(seen), 1);
        @(negedge clk);
    endtask

    task automatic run0(input int mode, input int glitch_at);
        exp_t e;
        mode0 = mode;
        e = ref_model(mode);
        q0.push_back(e);
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        if (glitch_at > 0) begin
            repeat (glitch_at) @(negedge clk);
            start0 = 1'b1;
            @(negedge clk);
            start0 = 1'b0;
        end
        wait_done0(NP + 40);
    endtask

    task automatic run2(input bit mis);
        exp_t e;
        mis2 = mis;
        e = ref_model(0);
        e.nz_only = mis;
        e.blen = NP + 2;
        q2.push_back(e);
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        wait_done2(NP + 40);
    endtask

    task automatic check_idle0(input string tag);
        check({tag, "_busy"}, int'(busy0), 0);
        check({tag, "_done"}, int'(done0), 0);
        check({tag, "_ops"}, int'({b0, a0}), 0);
        check({tag, "_err_cnt"}, int'(err0), 0);
        check({tag, "_sum_abs"}, int'(sum0), 0);
        check({tag, "_bias"}, int'(bias0), 0);
        check({tag, "_max_err"}, int'(max0), 0);
        check({tag, "_wce"}, int'({wb0, wa0}), 0);
    endtask

    initial begin : timeout
        #400000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        for (int i = 0; i < NP; i++) lut[i] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle0("reset");
        check("reset_lat2_busy", int'(busy2), 0);
        check("reset_lat2_done", int'(done2), 0);
        check("reset_lat2_ops", int'({b2, a2}), 0);

        // Exact model, with a start pulse landing mid-sweep
        run0(0, 50);
        run0(1, 0);
        run0(2, 0);
        run0(3, 0);

        // Randomly corrupted product tables
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < NP; i++)
                lut[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                     : 8'((i % 16) * (i / 16));
            run0(4, 0);
        end

        // Reset partway through a sweep discards it
        mode0 = 1;
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (99) @(negedge clk);
        check("midrst_busy_before", int'(busy0), 1);
        rst = 1'b1;
        @(negedge clk);
        check_idle0("midrst");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_no_done", int'(done0), 0);

        run0(0, 0);

        run2(1'b0);
        run2(1'b1);

        repeat (3) @(negedge clk);
        check("sb0_drained", q0.size(), 0);
        check("sb2_drained", q2.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
